// File: rtl/game_input_judge_pkg.sv
// Shared types and constants for the game input judge: FSM states,
// target LFSR definition and score limits.
package game_input_judge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_WAIT_PRESS,
    ST_WAIT_RELEASE
  } judge_state_t;

  localparam int LFSR_W = 8;
  // x^8 + x^6 + x^5 + x^4 + 1 -> bit indices 7, 5, 4, 3
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

  localparam int SCORE_W = 16;
  localparam logic [SCORE_W-1:0] SCORE_MAX = 16'hFFFF;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] cur);
    return {cur[LFSR_W-2:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/game_input_judge_btn_debounce.sv
// One push-button channel: 2-FF synchroniser, stable-time debounce and a
// registered rising-edge pulse of the debounced level.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_raw,
  output logic stable,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic             stable_q;
  logic             stable_d;
  logic             press_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_p0  <= 1'b0;
      sync_p1  <= 1'b0;
      stable_q <= 1'b0;
      stable_d <= 1'b0;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
      // Any return to the accepted level restarts the stability window.
      if (sync_p1 == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_q    <= '0;
        stable_q <= sync_p1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      stable_d <= stable_q;
      press_q  <= stable_q & ~stable_d;
    end
  end

  assign stable = stable_q;
  assign press  = press_q;

endmodule

// File: rtl/game_input_judge.sv
// Button front end of the countdown game: debounces the player buttons,
// draws a random target per round, judges presses and keeps the score.
module game_input_judge
  import game_input_judge_pkg::*;
#(
  parameter int               NUM_BTN         = 4,
  parameter int               DEBOUNCE_CYCLES = 500000,
  parameter logic [LFSR_W-1:0] LFSR_SEED      = 8'hA5
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [NUM_BTN-1:0]         btn_raw,
  output logic [$clog2(NUM_BTN)-1:0] target,
  output logic                       target_valid,
  output logic                       hit,
  output logic                       miss,
  output logic [SCORE_W-1:0]         score
);

  localparam int TGT_W = $clog2(NUM_BTN);
  localparam logic [NUM_BTN-1:0] ONE_BTN = NUM_BTN'(1);

  logic [NUM_BTN-1:0] stable;
  logic [NUM_BTN-1:0] press;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clock  (clock),
      .reset  (reset),
      .btn_raw(btn_raw[g]),
      .stable (stable[g]),
      .press  (press[g])
    );
  end

  judge_state_t       state_q;
  judge_state_t       state_d;
  logic [LFSR_W-1:0]  lfsr_q;
  logic [TGT_W-1:0]   target_q;
  logic [SCORE_W-1:0] score_q;
  logic               hit_q;
  logic               miss_q;
  logic               hit_d;
  logic               miss_d;
  logic               latch_target;
  logic               clear_score;
  logic               press_match;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (v == SCORE_MAX) ? v : v + 1'b1;
  endfunction

  // Only a single press of exactly the target button counts as a hit.
  assign press_match = (press == (ONE_BTN << target_q));

  always_comb begin
    state_d      = state_q;
    hit_d        = 1'b0;
    miss_d       = 1'b0;
    latch_target = 1'b0;
    clear_score  = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d     = ST_ARM;
          clear_score = 1'b1;
        end
        ST_ARM: begin
          state_d      = ST_WAIT_PRESS;
          latch_target = 1'b1;
        end
        ST_WAIT_PRESS: begin
          if (|press) begin
            state_d = ST_WAIT_RELEASE;
            hit_d   = press_match;
            miss_d  = ~press_match;
          end
        end
        ST_WAIT_RELEASE: begin
          if (stable == '0) state_d = ST_ARM;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      lfsr_q   <= LFSR_SEED;
      target_q <= '0;
      score_q  <= '0;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_step(lfsr_q);
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      if (latch_target) target_q <= lfsr_q[TGT_W-1:0];
      if (clear_score) score_q <= '0;
      else if (hit_d)  score_q <= sat_inc(score_q);
    end
  end

  assign target       = target_q;
  assign target_valid = (state_q == ST_WAIT_PRESS);
  assign hit          = hit_q;
  assign miss         = miss_q;
  assign score        = score_q;

endmodule

// File: tb/tb_game_input_judge.sv
// Scoreboard bench for game_input_judge with NUM_BTN=4, DEBOUNCE_CYCLES=4.
module tb_game_input_judge;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [3:0]  btn_raw = 4'b0;
  logic [1:0]  target;
  logic        target_valid;
  logic        hit;
  logic        miss;
  logic [15:0] score;

  game_input_judge #(
    .NUM_BTN        (4),
    .DEBOUNCE_CYCLES(4),
    .LFSR_SEED      (8'hA5)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .btn_raw     (btn_raw),
    .target      (target),
    .target_valid(target_valid),
    .hit         (hit),
    .miss        (miss),
    .score       (score)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        is_hit;
    logic [15:0] score;
    int          cyc;
  } ev_t;

  ev_t         exp_q[$];
  int          checks = 0;
  int          passes = 0;
  int          cyc = 0;
  logic [7:0]  lfsr_m;
  logic [7:0]  lfsr_prev;
  logic [1:0]  exp_target = 2'd0;
  logic [15:0] score_m = 16'd0;

  always @(posedge clock) cyc <= cyc + 1;

  // Reference LFSR: x^8+x^6+x^5+x^4+1, shifting left, seed A5.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      lfsr_m    <= 8'hA5;
      lfsr_prev <= 8'hA5;
    end else begin
      lfsr_prev <= lfsr_m;
      lfsr_m    <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [15:0] sat(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic expect_pulse(input logic is_hit, input int at_cyc);
    ev_t e;
    if (is_hit) score_m = sat(score_m);
    e.is_hit = is_hit;
    e.score  = score_m;
    e.cyc    = at_cyc;
    exp_q.push_back(e);
  endtask

  // Must be entered while target_valid is low so the first high sample
  // corresponds to the ARM cycle that latched lfsr_prev.
  task automatic wait_tv(input int budget);
    for (int i = 0; i < budget && !target_valid; i++) tick(1);
    if (!target_valid) begin
      check("target_valid_timeout", 32'd0, 32'd1);
    end else begin
      exp_target = lfsr_prev[1:0];
      check("target", {30'd0, target}, {30'd0, exp_target});
    end
  endtask

  task automatic press_round(input logic [3:0] mask);
    int r;
    expect_pulse(mask == (4'b0001 << exp_target), cyc + 8);
    btn_raw = mask;
    tick(10);
    btn_raw = 4'b0;
    r = cyc;
    wait_tv(30);
    check("release_to_target_valid", cyc - r, 32'd8);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_target"}, {30'd0, target}, 32'd0);
    check({tag, "_target_valid"}, {31'd0, target_valid}, 32'd0);
    check({tag, "_hit"}, {31'd0, hit}, 32'd0);
    check({tag, "_miss"}, {31'd0, miss}, 32'd0);
    check({tag, "_score"}, {16'd0, score}, 32'd0);
    check({tag, "_lfsr"}, {24'd0, dut.lfsr_q}, 32'h0000_00A5);
  endtask

  // Monitor: every pulse the DUT emits must match the head of the queue.
  always @(negedge clock) begin
    ev_t e;
    if (!reset) begin
      if (hit && miss) check("hit_miss_exclusive", 32'd1, 32'd0);
      if (hit || miss) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {30'd0, hit, miss}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("pulse_kind_hit", {31'd0, hit}, {31'd0, e.is_hit});
          check("pulse_cycle", cyc, e.cyc);
          check("score_at_pulse", {16'd0, score}, {16'd0, e.score});
        end
      end
    end
  end

  initial begin
    int c;
    logic [1:0] t_alt;
    logic [3:0] tmask;

    tick(3);
    check_reset_outputs("reset");
    #2 reset = 1'b0;
    tick(5);
    check("idle_target_valid", {31'd0, target_valid}, 32'd0);
    check("idle_score", {16'd0, score}, 32'd0);

    // Correct press
    enable = 1'b1;
    c = cyc;
    wait_tv(10);
    check("enable_to_target_valid", cyc - c, 32'd2);
    check("lfsr_track", {24'd0, dut.lfsr_q}, {24'd0, lfsr_m});
    press_round(4'b0001 << exp_target);

    // Wrong button, then two buttons at once
    t_alt = exp_target + 2'd1;
    press_round(4'b0001 << t_alt);
    t_alt = exp_target + 2'd2;
    press_round((4'b0001 << exp_target) | (4'b0001 << t_alt));

    // Bounce, then a steady hold
    tmask = 4'b0001 << exp_target;
    for (int i = 0; i < 10; i++) begin
      btn_raw = (i % 2 == 0) ? tmask : 4'b0;
      tick(2);
    end
    expect_pulse(1'b1, cyc + 8);
    btn_raw = tmask;
    tick(10);
    btn_raw = 4'b0;
    wait_tv(30);

    // Short glitch leaves the round open
    btn_raw = 4'b0001 << exp_target;
    tick(3);
    btn_raw = 4'b0;
    tick(10);
    check("glitch_keeps_round", {31'd0, target_valid}, 32'd1);

    // Button held across ARM
    enable = 1'b0;
    tick(2);
    check("disable_to_idle", {31'd0, target_valid}, 32'd0);
    btn_raw = 4'b0001;
    tick(10);
    enable = 1'b1;
    score_m = 16'd0;
    wait_tv(10);
    check("score_clear_on_enable", {16'd0, score}, 32'd0);
    tick(10);
    check("held_no_judgement", {31'd0, target_valid}, 32'd1);
    btn_raw = 4'b0;
    tick(10);
    check("release_no_judgement", {31'd0, target_valid}, 32'd1);
    press_round(4'b0001 << exp_target);

    // Enable dropped on the judgement cycle
    btn_raw = 4'b0001 << exp_target;
    tick(7);
    enable = 1'b0;
    tick(1);
    check("drop_enable_idle", {31'd0, target_valid}, 32'd0);
    check("drop_enable_no_hit", {31'd0, hit}, 32'd0);
    check("drop_enable_score", {16'd0, score}, {16'd0, score_m});
    btn_raw = 4'b0;
    tick(10);

    // Score saturation, then clear by re-enabling
    enable = 1'b1;
    score_m = 16'd0;
    wait_tv(10);
    force dut.score_q = 16'hFFFF;
    tick(1);
    release dut.score_q;
    score_m = 16'hFFFF;
    check("score_preload", {16'd0, score}, 32'h0000_FFFF);
    press_round(4'b0001 << exp_target);
    check("score_saturated", {16'd0, score}, 32'h0000_FFFF);
    enable = 1'b0;
    tick(2);
    enable = 1'b1;
    score_m = 16'd0;
    wait_tv(10);
    check("score_cleared", {16'd0, score}, 32'd0);

    // Reset in the middle of a round with a nonzero score
    expect_pulse(1'b1, cyc + 8);
    btn_raw = 4'b0001 << exp_target;
    tick(9);
    check("pre_reset_score", {16'd0, score}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check_reset_outputs("midrun_reset");
    enable = 1'b0;
    btn_raw = 4'b0;
    #2 reset = 1'b0;
    score_m = 16'd0;
    tick(5);
    check("post_reset_target_valid", {31'd0, target_valid}, 32'd0);
    check("post_reset_score", {16'd0, score}, 32'd0);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/game_input_judge.md
# game_input_judge

Upstream stage of the game countdown timer. Synchronises and debounces the player push-buttons, draws a pseudo-random target button each round, and judges each press. It emits one-cycle `hit`/`miss` pulses; `miss` drives the timer's penalty input directly. It also keeps a saturating score.

## Interface
- `NUM_BTN`, 4: number of player buttons; power of two, 2..8.
- `DEBOUNCE_CYCLES`, 500000: consecutive stable cycles before a button change is accepted (10 ms at 50 MHz).
- `LFSR_SEED`, 8'hA5: nonzero reset value of the target LFSR.
- `clock` in 1: system clock, 50 MHz.
- `reset` in 1: asynchronous, active-high.
- `enable` in 1: game active; the top level drives it low on game fail.
- `btn_raw` in NUM_BTN: raw asynchronous buttons, active-high.
- `target` out $clog2(NUM_BTN): button the player must press this round.
- `target_valid` out 1: high while a press is being awaited.
- `hit` out 1: one-cycle pulse on a correct press.
- `miss` out 1: one-cycle pulse on a wrong or multiple press.
- `score` out 16: count of hits, saturating at 16'hFFFF.

## Operation
- **Synchroniser:** 2-FF per button bit, reset to 0.
- **Debounce:**
  - Each bit has a counter and a stable flag.
  - While the synced value differs from the stable value, the counter increments.
  - While they match, the counter clears.
  - When the counter reaches DEBOUNCE_CYCLES-1 with a mismatch, the stable value flips and the counter clears.
  - Counter width is $clog2(DEBOUNCE_CYCLES).
- **Press event:** `press[i]` is a one-cycle rising edge of stable bit i, registered.
- **LFSR:**
  - 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1.
  - Free-running every cycle from reset; never all-zero.
  - The target is taken from `lfsr[$clog2(NUM_BTN)-1:0]`.
- **FSM states:** IDLE, ARM, WAIT_PRESS, WAIT_RELEASE.
  - IDLE: outputs quiet. When `enable`=1, go to ARM.
  - ARM (one cycle): latch `target` from the LFSR, go to WAIT_PRESS. ARM entered from IDLE also clears `score`.
  - WAIT_PRESS: `target_valid`=1. On any nonzero `press`, judge it and go to WAIT_RELEASE:
    - exactly one bit set, and its index equals `target` -> hit; `score` increments (saturating).
    - anything else -> miss.
  - WAIT_RELEASE: wait until all stable bits are 0, then go to ARM.
  - `enable`=0 in any state -> IDLE on the next edge. A judgement in that same cycle is suppressed: no pulse, no score change.
- **Held buttons:** a button already held when WAIT_PRESS is entered produces no event until it is released and pressed again.
- **Reset values:**
  - FSM: IDLE.
  - `target`: 0. `target_valid`: 0. `hit`: 0. `miss`: 0. `score`: 0.
  - All debounce state: 0. LFSR: LFSR_SEED.
- **Mid-operation reset:** every output returns to its reset value immediately (asynchronous). The FSM resumes from IDLE.

## Timing
- Raw stable edge -> stable flag flips: 2 + DEBOUNCE_CYCLES cycles.
- Stable flip -> `press`: +1 cycle.
- `press` -> `hit`/`miss`: +1 cycle. `score` updates on the same edge as `hit` rises.
- `hit` and `miss` are never high together.
- At most one pulse per round. Pulses are exactly one clock wide.
- Release -> next `target_valid`: stable all-zero seen in WAIT_RELEASE, +1 cycle for ARM, +1 cycle to WAIT_PRESS.
- Two buttons whose stable flags rise on the same cycle count as a multiple press -> miss.

## Structure
- **Shared package:**
  - FSM state enum.
  - LFSR tap mask and width constant (8).
  - Score width (16) and saturation value.
- **Sub-module `btn_debounce`:**
  - Contents: one bit's synchroniser, debounce counter and rising-edge register, parameterised by DEBOUNCE_CYCLES.
  - Instantiated NUM_BTN times with a generate loop.
  - The judge FSM, LFSR and score stay in the top module.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and NUM_BTN=4.
- **Reset:** assert `reset` mid-run -> all outputs 0 and LFSR = 8'hA5 in the same cycle; after release with `enable`=0, outputs stay quiet.
- **Correct press:** enable, read `target`=T, hold `btn_raw[T]` for 10 cycles -> single `hit` exactly 2+4+2 cycles after the raw edge; `score`=1; no `miss`.
- **Wrong and multiple press:** press button (T+1)%4 -> one `miss`, `score` unchanged. Next round, press two buttons on the same cycle -> one `miss`.
- **Bounce:** toggle the target button every 2 cycles for 20 cycles, then hold -> exactly one `hit`, none during the bounce. A 3-cycle glitch -> no event.
- **Hold/release and disable:**
  - Keep a button held across ARM -> no judgement until it is released and re-pressed.
  - Drop `enable` on the cycle a press is judged -> no pulse, FSM in IDLE next cycle.
- **Score saturation and clear:** force `score` to 16'hFFFF, then a hit -> `score` stays 16'hFFFF. Toggle `enable` 0->1 -> `score`=0.
